// File: rtl/uart_prog_loader_pkg.sv
// Shared state encodings and constants for the UART program loader.
package uart_prog_loader_pkg;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  typedef enum logic [2:0] {
    LCntHi,
    LCntLo,
    LWHi,
    LWLo,
    LWrite
  } ld_state_e;

  // Stream header: COUNT_HI, COUNT_LO
  localparam int unsigned HeaderBytes = 2;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Instruction-memory load port and status driven by the boot loader.
interface uart_prog_loader_if;
  logic [15:0] uart_read_addr;
  logic [15:0] uart_read_data;
  logic        prog_we;
  logic        prog_ld;
  logic        load_done;
  logic        frame_err;
  logic [15:0] words_loaded;

  modport master (
    output uart_read_addr, uart_read_data, prog_we, prog_ld, load_done, frame_err, words_loaded
  );

  modport slave (
    input uart_read_addr, uart_read_data, prog_we, prog_ld, load_done, frame_err, words_loaded
  );
endinterface

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle valid/error pulses.
module uart_prog_loader_rx
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       pc_reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]      sync_q;
  logic            prev_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (pc_reset) begin
      // Idle-high so a reset never looks like a start edge
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RxIdle: begin
        if (prev_q && !rx_s) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RxStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (cnt_q == BitLast) begin
          state_d = RxIdle;
          valid_d = rx_s;
          err_d   = !rx_s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign rx_byte    = shift_q;
  assign byte_valid = valid_q;
  assign byte_err   = err_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Serial boot loader: streams a counted, big-endian 16-bit program image into instruction memory.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic                clk,
  input  logic                pc_reset,
  input  logic                rx,
  uart_prog_loader_if.master  lp
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       byte_err;

  uart_prog_loader_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .pc_reset  (pc_reset),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .byte_err  (byte_err)
  );

  ld_state_e   state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] words_q, words_d;
  logic        we_q, we_d;
  logic        ld_q, ld_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (pc_reset) begin
      state_q <= LCntHi;
      count_q <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      words_q <= words_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    data_d  = data_q;
    words_d = words_q;
    ld_d    = ld_q;
    ferr_d  = ferr_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    if (byte_err) begin
      // Abort: already-written words stay in memory, no completion pulse
      ferr_d  = 1'b1;
      ld_d    = 1'b0;
      state_d = LCntHi;
    end else begin
      case (state_q)
        LCntHi: begin
          if (byte_valid) begin
            count_d[15:8] = rx_byte;
            ld_d          = 1'b1;
            words_d       = '0;
            addr_d        = '0;
            state_d       = LCntLo;
          end
        end
        LCntLo: begin
          if (byte_valid) begin
            count_d[7:0] = rx_byte;
            if ({count_q[15:8], rx_byte} == 16'd0) begin
              done_d  = 1'b1;
              ld_d    = 1'b0;
              state_d = LCntHi;
            end else begin
              state_d = LWHi;
            end
          end
        end
        LWHi: begin
          if (byte_valid) begin
            hi_d    = rx_byte;
            state_d = LWLo;
          end
        end
        LWLo: begin
          if (byte_valid) begin
            data_d  = {hi_q, rx_byte};
            we_d    = 1'b1;
            state_d = LWrite;
          end
        end
        LWrite: begin
          addr_d  = addr_q + 16'd1;
          words_d = words_q + 16'd1;
          if (words_q + 16'd1 == count_q) begin
            done_d  = 1'b1;
            ld_d    = 1'b0;
            state_d = LCntHi;
          end else begin
            state_d = LWHi;
          end
        end
        default: state_d = LCntHi;
      endcase
    end
  end

  assign lp.uart_read_addr = addr_q;
  assign lp.uart_read_data = data_q;
  assign lp.prog_we        = we_q;
  assign lp.prog_ld        = ld_q;
  assign lp.load_done      = done_q;
  assign lp.frame_err      = ferr_q;
  assign lp.words_loaded   = words_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench: stimulus queues expected writes/completions, a monitor checks them on negedge.
module tb_uart_prog_loader;

  logic clk = 1'b0;
  logic pc_reset;
  logic rx;

  always #5 clk = ~clk;

  uart_prog_loader_if lp ();

  uart_prog_loader #(
    .CLK_HZ(1000000),
    .BAUD  (100000)
  ) dut (
    .clk     (clk),
    .pc_reset(pc_reset),
    .rx      (rx),
    .lp      (lp)
  );

  typedef struct {
    bit          is_done;
    logic [15:0] a;  // write address, or expected words_loaded for a completion
    logic [15:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    e.is_done = 1'b0;
    e.a       = a;
    e.d       = d;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic [15:0] n);
    ev_t e;
    e.is_done = 1'b1;
    e.a       = n;
    e.d       = 16'd0;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v);
    @(posedge clk);
    #1 rx = v;
    repeat (9) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (!stop_ok) drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check(name, 16'(exp_q.size()), 16'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, lp.uart_read_addr, 16'd0);
    check({tag, "_data"}, lp.uart_read_data, 16'd0);
    check({tag, "_we"}, 16'(lp.prog_we), 16'd0);
    check({tag, "_ld"}, 16'(lp.prog_ld), 16'd0);
    check({tag, "_done"}, 16'(lp.load_done), 16'd0);
    check({tag, "_ferr"}, 16'(lp.frame_err), 16'd0);
    check({tag, "_words"}, lp.words_loaded, 16'd0);
  endtask

  // Monitor: every write strobe or completion pulse must match the next expected event
  ev_t mon_e;
  always @(negedge clk) begin
    if (!pc_reset && (lp.prog_we || lp.load_done)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got we=%b done=%b expected none", lp.prog_we,
                 lp.load_done);
      end else begin
        mon_e = exp_q.pop_front();
        if (lp.prog_we) begin
          check("ev_is_write", 16'(mon_e.is_done), 16'd0);
          check("wr_addr", lp.uart_read_addr, mon_e.a);
          check("wr_data", lp.uart_read_data, mon_e.d);
          check("wr_prog_ld", 16'(lp.prog_ld), 16'd1);
        end else begin
          check("ev_is_done", 16'(mon_e.is_done), 16'd1);
          check("done_words", lp.words_loaded, mon_e.a);
          check("done_prog_ld", 16'(lp.prog_ld), 16'd0);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rx       = 1'b1;
    pc_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 pc_reset = 1'b0;
    check_all_zero("rst");

    // Three-word load
    push_wr(16'd0, 16'h1234);
    push_wr(16'd1, 16'hABCD);
    push_wr(16'd2, 16'h000F);
    push_done(16'd3);
    send_byte(8'h00, 1'b1);
    check("t1_ld_after_hdr", 16'(lp.prog_ld), 16'd1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h0F, 1'b1);
    drain("t1_drain");
    repeat (5) @(posedge clk);
    #1;
    check("t1_ld_end", 16'(lp.prog_ld), 16'd0);
    check("t1_words", lp.words_loaded, 16'd3);
    check("t1_ferr", 16'(lp.frame_err), 16'd0);

    // Zero-length load
    push_done(16'd0);
    send_byte(8'h00, 1'b1);
    check("t2_ld_mid", 16'(lp.prog_ld), 16'd1);
    send_byte(8'h00, 1'b1);
    drain("t2_drain");
    #1;
    check("t2_ld_end", 16'(lp.prog_ld), 16'd0);
    check("t2_words", lp.words_loaded, 16'd0);

    // Framing error aborts the load; error flag is sticky
    push_wr(16'd0, 16'h1122);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    drain("t3_drain_a");
    #1;
    check("t3_ferr_set", 16'(lp.frame_err), 16'd1);
    check("t3_ld_abort", 16'(lp.prog_ld), 16'd0);
    push_wr(16'd0, 16'h5566);
    push_done(16'd1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    drain("t3_drain_b");
    #1;
    check("t3_ferr_sticky", 16'(lp.frame_err), 16'd1);
    check("t3_words", lp.words_loaded, 16'd1);

    // False start: short low glitch while idle
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("t4_ld_idle", 16'(lp.prog_ld), 16'd0);
    check("t4_words", lp.words_loaded, 16'd1);

    // Reset in the middle of the second word of a four-word load
    push_wr(16'd0, 16'h0102);
    send_byte(8'h00, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    drain("t5_drain_a");
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    @(posedge clk);
    #1 pc_reset = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    #1 pc_reset = 1'b0;
    check_all_zero("t5_rst");
    repeat (40) @(posedge clk);
    push_wr(16'd0, 16'hAABB);
    push_done(16'd1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    drain("t5_drain_b");

    // Back-to-back streams both restart at address 0
    push_wr(16'd0, 16'hDEAD);
    push_done(16'd1);
    push_wr(16'd0, 16'hBEEF);
    push_done(16'd1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    drain("t6_drain");
    #1;
    check("t6_ld_end", 16'(lp.prog_ld), 16'd0);
    check("t6_ferr", 16'(lp.frame_err), 16'd0);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
